axil_reg_slave: RTL and testbench

AXI4-Lite responder (slave) exposing a bank of `NUM_REGS` 32-bit read/write registers to fabric logic. It is the target end of the `axi_lite_if` bus: masters and bench agents drive AW/W/AR and it answers on B/R. Register contents are presented as a flat parallel vector, and a one-cycle strobe marks each committed write. One write and one read may be in flight at once, each with a single outstanding transaction.

---
 rtl/axi_lite_if.sv | 36 +++
 rtl/axil_reg_slave.sv | 245 ++++++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: AW/W/B write channels and AR/R read channels.
// master drives requests and ready for responses; slave answers them.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder over NUM_REGS 32-bit read/write registers with byte strobes.
// Define AXIL_REG_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axi_lite_if.slave                s_axi,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_REG_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_reg_slave: DATA_WIDTH must be 32");
  end
  if ((NUM_REGS < 2) || (NUM_REGS > 256) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
    $error("axil_reg_slave: NUM_REGS must be a power of two in 2..256");
  end
  if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr_width
    $error("axil_reg_slave: ADDR_WIDTH too small for NUM_REGS");
  end

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wstate_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + 2)) == {ADDR_WIDTH{1'b0}};
  endfunction

  wstate_e                     wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0]       awaddr_q, awaddr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [3:0]                  wstrb_q, wstrb_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [NUM_REGS-1:0][31:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0]         reg_wr_q, reg_wr_d;
  logic                        rvalid_q, rvalid_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic                        aw_held_s, w_held_s, bvalid_s;
  logic                        awready_s, wready_s, arready_s;
  logic                        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [ADDR_WIDTH-1:0]       wr_addr_s;
  logic [31:0]                 wr_data_s;
  logic [3:0]                  wr_strb_s;

  // Write FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
    end else begin
      wstate_q <= wstate_d;
    end
  end

  // Write FSM next state: advance on each accepted beat, leave W_RESP on B handshake.
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          wstate_d = W_RESP;
        end else if (aw_hs_s) begin
          wstate_d = W_HAVE_A;
        end else if (w_hs_s) begin
          wstate_d = W_HAVE_D;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_HAVE_A: begin
        if (w_hs_s) begin
          wstate_d = W_RESP;
        end else begin
          wstate_d = W_HAVE_A;
        end
      end
      W_HAVE_D: begin
        if (aw_hs_s) begin
          wstate_d = W_RESP;
        end else begin
          wstate_d = W_HAVE_D;
        end
      end
      W_RESP: begin
        if (s_axi.BREADY) begin
          wstate_d = W_IDLE;
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write FSM outputs and bus readies.
  always_comb begin
    aw_held_s = 1'b0;
    w_held_s  = 1'b0;
    bvalid_s  = 1'b0;
    case (wstate_q)
      W_IDLE:   begin end
      W_HAVE_A: aw_held_s = 1'b1;
      W_HAVE_D: w_held_s  = 1'b1;
      W_RESP:   bvalid_s  = 1'b1;
      default:  bvalid_s  = 1'b0;
    endcase
    awready_s = !aw_held_s && !bvalid_s && !ARESET;
    wready_s  = !w_held_s && !bvalid_s && !ARESET;
    arready_s = !rvalid_q && !ARESET;
  end

  // Handshakes and the commit beat: held buffer content wins over the live bus.
  always_comb begin
    aw_hs_s   = s_axi.AWVALID && awready_s;
    w_hs_s    = s_axi.WVALID && wready_s;
    ar_hs_s   = s_axi.ARVALID && arready_s;
    commit_s  = (aw_held_s || aw_hs_s) && (w_held_s || w_hs_s);
    wr_addr_s = aw_held_s ? awaddr_q : s_axi.AWADDR;
    wr_data_s = w_held_s ? wdata_q : s_axi.WDATA;
    wr_strb_s = w_held_s ? wstrb_q : s_axi.WSTRB;
  end

  // Holding buffers; capture is harmless when the beat commits the same cycle.
  always_comb begin
    if (aw_hs_s) begin
      awaddr_d = s_axi.AWADDR;
    end else begin
      awaddr_d = awaddr_q;
    end
    if (w_hs_s) begin
      wdata_d = s_axi.WDATA;
      wstrb_d = s_axi.WSTRB;
    end else begin
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
    end
  end

  // Register bank update, write strobe and write response on commit.
  always_comb begin
    regs_d   = regs_q;
    reg_wr_d = {NUM_REGS{1'b0}};
    bresp_d  = bresp_q;
    if (commit_s) begin
      if (addr_ok(wr_addr_s)) begin
        regs_d[addr_idx(wr_addr_s)]   = apply_strb(regs_q[addr_idx(wr_addr_s)], wr_data_s, wr_strb_s);
        reg_wr_d[addr_idx(wr_addr_s)] = 1'b1;
        bresp_d                       = RESP_OKAY;
      end else begin
        bresp_d = SLVERR_EN ? RESP_SLVERR : RESP_OKAY;
      end
    end else begin
      bresp_d = bresp_q;
    end
  end

  // Read channel: sample regs_q (pre-write value) on AR, hold until R handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      if (addr_ok(s_axi.ARADDR)) begin
        rdata_d = regs_q[addr_idx(s_axi.ARADDR)];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = 32'h0000_0000;
        rresp_d = SLVERR_EN ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (rvalid_q && s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awaddr_q <= {ADDR_WIDTH{1'b0}};
      wdata_q  <= 32'h0000_0000;
      wstrb_q  <= 4'h0;
      bresp_q  <= 2'b00;
      regs_q   <= {(NUM_REGS*32){1'b0}};
      reg_wr_q <= {NUM_REGS{1'b0}};
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      rresp_q  <= 2'b00;
    end else begin
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      regs_q   <= regs_d;
      reg_wr_q <= reg_wr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_axi.AWREADY = awready_s;
  assign s_axi.WREADY  = wready_s;
  assign s_axi.BVALID  = bvalid_s;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready_s;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign reg_q         = regs_q;
  assign reg_wr        = reg_wr_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: inputs driven on the falling edge, outputs sampled there.
module tb_axil_reg_slave;

  localparam int AW = 32;
  localparam int NR = 16;
`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr;
  logic [NR-1:0][31:0] shadow;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  axil_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s_axi  (bus),
    .reg_q  (reg_q),
    .reg_wr (reg_wr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
    bus.BREADY = 1'b0;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
  endtask

  task automatic b_ack();
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic rd_start(input logic [31:0] a);
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    tick();
    bus.ARVALID = 1'b0;
  endtask

  task automatic r_ack();
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.AWADDR = 32'h0; bus.AWVALID = 1'b0; bus.WDATA = 32'h0; bus.WSTRB = 4'h0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = 32'h0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    shadow = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_awready", bus.AWREADY, 1'b0);
    chk("rst_wready", bus.WREADY, 1'b0);
    chk("rst_arready", bus.ARREADY, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    chk("post_rst_valids", {bus.BVALID, bus.RVALID}, 2'b00);
    chk("post_rst_resps", {bus.BRESP, bus.RRESP}, 4'h0);
    chk("post_rst_rdata", bus.RDATA, 32'h0);
    chk("post_rst_reg_q", reg_q, 512'h0);
    chk("post_rst_reg_wr", reg_wr, 16'h0);

    // Same-cycle AW+W to 0x08
    wr_start(32'h08, 32'hDEADBEEF, 4'hF);
    shadow[2] = 32'hDEADBEEF;
    chk("t1_bvalid", bus.BVALID, 1'b1);
    chk("t1_bresp", bus.BRESP, 2'b00);
    chk("t1_reg2", reg_q[95:64], 32'hDEADBEEF);
    chk("t1_reg_wr", reg_wr, 16'h0004);
    chk("t1_readies_busy", {bus.AWREADY, bus.WREADY}, 2'b00);
    b_ack();
    chk("t1_bvalid_drop", bus.BVALID, 1'b0);
    chk("t1_reg_wr_drop", reg_wr, 16'h0);
    rd_start(32'h08);
    chk("t1_rvalid", bus.RVALID, 1'b1);
    chk("t1_rdata", bus.RDATA, 32'hDEADBEEF);
    chk("t1_rresp", bus.RRESP, 2'b00);
    r_ack();
    chk("t1_rvalid_drop", bus.RVALID, 1'b0);

    // W three cycles ahead of AW to 0x04
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t2_wready_held", {bus.WREADY, bus.AWREADY, bus.BVALID}, 3'b010);
      tick();
    end
    chk("t2_wready_held3", bus.WREADY, 1'b0);
    chk("t2_no_early_commit", reg_q[63:32], 32'h0);
    bus.AWADDR = 32'h04; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    shadow[1] = 32'h11223344;
    chk("t2_bvalid", bus.BVALID, 1'b1);
    chk("t2_reg1", reg_q[63:32], 32'h11223344);
    chk("t2_reg_wr", reg_wr, 16'h0002);
    b_ack();
    wr_start(32'h04, 32'hAABBCCDD, 4'h2);
    shadow[1] = 32'h1122CC44;
    chk("t2_strb_reg_q", reg_q, shadow);
    chk("t2_strb_reg_wr", reg_wr, 16'h0002);
    b_ack();
    rd_start(32'h04);
    chk("t2_strb_rdata", bus.RDATA, 32'h1122CC44);
    r_ack();

    // Read 0x0C held off by RREADY for five cycles
    wr_start(32'h0C, 32'hCAFEF00D, 4'hF);
    shadow[3] = 32'hCAFEF00D;
    b_ack();
    rd_start(32'h0C);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall", {bus.RVALID, bus.ARREADY, bus.RDATA}, {1'b1, 1'b0, 32'hCAFEF00D});
      tick();
    end
    r_ack();
    chk("t3_after_hs", {bus.RVALID, bus.ARREADY}, 2'b01);

    // Read and write to register 0 in the same cycle
    wr_start(32'h00, 32'h00000007, 4'hF);
    shadow[0] = 32'h7;
    b_ack();
    bus.ARADDR = 32'h00; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    bus.AWADDR = 32'h00; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h55; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    tick();
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    shadow[0] = 32'h55;
    chk("t4_rdata_old", bus.RDATA, 32'h7);
    chk("t4_both_valid", {bus.BVALID, bus.RVALID}, 2'b11);
    chk("t4_reg_q", reg_q, shadow);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    rd_start(32'h00);
    chk("t4_rdata_new", bus.RDATA, 32'h55);
    r_ack();

    // Out-of-range 0x40
    wr_start(32'h40, 32'hFFFFFFFF, 4'hF);
    chk("t5_bvalid", bus.BVALID, 1'b1);
    chk("t5_bresp", bus.BRESP, EXP_OOR);
    chk("t5_regs_same", reg_q, shadow);
    chk("t5_reg_wr", reg_wr, 16'h0);
    b_ack();
    rd_start(32'h40);
    chk("t5_rvalid", bus.RVALID, 1'b1);
    chk("t5_rdata", bus.RDATA, 32'h0);
    chk("t5_rresp", bus.RRESP, EXP_OOR);
    r_ack();

    // Reset with address held and a read pending
    bus.AWADDR = 32'h10; bus.AWVALID = 1'b1;
    bus.ARADDR = 32'h08; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    tick();
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    chk("t6_have_a", {bus.AWREADY, bus.WREADY, bus.RVALID}, 3'b011);
    rst = 1'b1;
    tick();
    chk("t6_in_rst", {bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY}, 5'b00000);
    chk("t6_regs_zero", reg_q, 512'h0);
    rst = 1'b0;
    #1;
    chk("t6_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    bus.WDATA = 32'h12345678; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    chk("t6_no_stale_commit", {bus.BVALID, reg_wr}, 17'h0);
    chk("t6_regs_still_zero", reg_q, 512'h0);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick();
    chk("t6_no_stale_resp", {bus.BVALID, bus.RVALID}, 2'b00);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
